// File: rtl/mem_stage_pkg.sv
// Shared core definitions for the memory stage: access size encodings,
// exception cause codes, write-back select encodings, the stage FSM state
// type and the alignment check helper.
package mem_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] ECAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_LOAD = 2'd1;
  localparam logic [1:0] WSEL_CSR  = 2'd2;
  localparam logic [1:0] WSEL_PC   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data bus between the memory stage and the data memory.
//   master (stage): drives mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb;
//                   receives mem_rdata, mem_ack.
//   slave (memory): the mirror image.
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load data steering: shifts the addressed byte/half down to
// bit 0 and sign- or zero-extends it. Word loads pass through untouched.
// Ports: rdata (raw bus word), off (byte offset), size, sign -> data.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      SIZE_BYTE: data = sign ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      SIZE_HALF: data = sign ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Issues aligned load/store transactions on
// the data bus, formats load data, raises misalignment exceptions and
// registers all write-back control for the next stage.
// Ports: clk, reset (sync, active-high); execute-side *_in fields; stall,
// invalidate from the hazard unit; busy_out to the hazard unit; registered
// write-back *_out fields; bus (data bus master).
//
// state | meaning
// IDLE  | no transaction; non-memory instructions flow through in one cycle
// WAIT  | request issued, waiting for mem_ack
// DONE  | ack arrived while stalled; load data parked in the buffer
// DRAIN | instruction flushed, request still up until the slave acks
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        branch_taken_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  load_store_size_in,
  input  logic        load_signed_in,
  input  logic        bypass_memory_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_address_in,
  input  logic [11:0] csr_address_in,
  input  logic        csr_write_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        valid_in,
  input  logic [3:0]  ecause_in,
  input  logic        exception_in,

  input  logic        stall,
  input  logic        invalidate,
  output logic        busy_out,

  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [31:0] load_data_out,
  output logic        branch_taken_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_address_out,
  output logic        bypass_memory_out,
  output logic [11:0] csr_address_out,
  output logic        csr_write_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic        valid_out,
  output logic [3:0]  ecause_out,
  output logic        exception_out,

  mem_stage_if.master bus
);

  mem_state_e  state, state_nx;

  logic        misaligned, mis_exc, access;
  logic        issue, req_clr, park, commit_done, upd;
  logic [3:0]  strb_nx;
  logic [31:0] wdata_nx, aligned, ld_nx;

  logic        req_q, we_q, sign_q;
  logic [31:0] addr_q, wdata_q, buf_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  off_q, size_q;

  assign misaligned = is_misaligned(load_store_size_in, alu_data_in[1:0]);
  assign mis_exc    = valid_in & (load_in | store_in) & ~exception_in & misaligned;
  assign access     = valid_in & (load_in | store_in) & ~exception_in & ~misaligned;

  always_comb begin
    case (load_store_size_in)
      SIZE_BYTE: begin
        strb_nx  = 4'b0001 << alu_data_in[1:0];
        wdata_nx = {4{rs2_data_in[7:0]}};
      end
      SIZE_HALF: begin
        strb_nx  = 4'b0011 << alu_data_in[1:0];
        wdata_nx = {2{rs2_data_in[15:0]}};
      end
      default: begin
        strb_nx  = 4'b1111;
        wdata_nx = rs2_data_in;
      end
    endcase
  end

  load_align u_load_align (
    .rdata (bus.mem_rdata),
    .off   (off_q),
    .size  (size_q),
    .sign  (sign_q),
    .data  (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    busy_out    = 1'b0;
    issue       = 1'b0;
    req_clr     = 1'b0;
    park        = 1'b0;
    commit_done = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_out = access;
        if (access && !invalidate) begin
          issue    = 1'b1;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy_out = ~bus.mem_ack;
        if (bus.mem_ack) begin
          req_clr  = 1'b1;
          park     = stall & ~invalidate;
          state_nx = park ? ST_DONE : ST_IDLE;
        end else if (invalidate) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DONE: begin
        busy_out = 1'b1;
        if (invalidate) begin
          state_nx = ST_IDLE;
        end else if (!stall) begin
          commit_done = 1'b1;
          state_nx    = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        busy_out = 1'b1;
        if (bus.mem_ack) begin
          req_clr  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      if (issue) begin
        req_q   <= 1'b1;
        we_q    <= store_in;
        addr_q  <= {alu_data_in[31:2], 2'b00};
        wdata_q <= store_in ? wdata_nx : '0;
        wstrb_q <= store_in ? strb_nx : 4'b0000;
        off_q   <= alu_data_in[1:0];
        size_q  <= load_store_size_in;
        sign_q  <= load_signed_in;
      end else if (req_clr) begin
        req_q <= 1'b0;
      end
      if (park) buf_q <= we_q ? '0 : aligned;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  // A WAIT-state ack without stall is already covered by !busy_out; only the
  // parked DONE result needs an explicit commit.
  assign upd = (~stall & ~busy_out) | commit_done;

  always_comb begin
    ld_nx = '0;
    if (commit_done)                          ld_nx = buf_q;
    else if (state == ST_WAIT && bus.mem_ack) ld_nx = we_q ? '0 : aligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out            <= '0;
      next_pc_out       <= '0;
      alu_data_out      <= '0;
      csr_data_out      <= '0;
      load_data_out     <= '0;
      branch_taken_out  <= 1'b0;
      write_select_out  <= '0;
      rd_address_out    <= '0;
      bypass_memory_out <= 1'b0;
      csr_address_out   <= '0;
      csr_write_out     <= 1'b0;
      mret_out          <= 1'b0;
      wfi_out           <= 1'b0;
      valid_out         <= 1'b0;
      ecause_out        <= '0;
      exception_out     <= 1'b0;
    end else begin
      // The parked instruction was a valid access, so its commit is valid.
      valid_out <= commit_done ? 1'b1
                 : ((stall ? valid_out : (valid_in & ~busy_out)) & ~invalidate);
      if (upd) begin
        pc_out            <= pc_in;
        next_pc_out       <= next_pc_in;
        alu_data_out      <= alu_data_in;
        csr_data_out      <= csr_data_in;
        load_data_out     <= ld_nx;
        branch_taken_out  <= branch_taken_in;
        write_select_out  <= write_select_in;
        rd_address_out    <= rd_address_in;
        bypass_memory_out <= bypass_memory_in;
        csr_address_out   <= csr_address_in;
        csr_write_out     <= csr_write_in;
        mret_out          <= mret_in;
        wfi_out           <= wfi_in;
        exception_out     <= exception_in | mis_exc;
        if (exception_in)  ecause_out <= ecause_in;
        else if (mis_exc)  ecause_out <= load_in ? ECAUSE_LOAD_MISALIGNED : ECAUSE_STORE_MISALIGNED;
        else               ecause_out <= ecause_in;
      end
    end
  end

endmodule
